rvfi_cover_monitor: RTL and testbench

// - Synthesizable retirement-event coverage monitor on the RVFI bus of minrv32.
// - Counts five event classes over NRET retire channels with saturating counters.
// - Exposes hit flags, goal flags and a run/done state machine.
// - Usable as formal cover targets and as an on-chip self-test progress indicator.

---
 rtl/rvfi_cover_monitor.sv | 199 +++++++++++++++++++
 tb/tb_rvfi_cover_monitor.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvfi_cover_monitor.sv
// -----------------------------------------------------------------------------
// rvfi_cover_monitor
//
// Retirement-event coverage monitor for the minrv32 RVFI bus. Each cycle, every
// valid retire channel is classified into up to five event classes. Each class
// has a saturating counter, a hit flag and a goal flag. A small run/done state
// machine tracks when every class has reached its target count. The block can
// serve as a set of formal cover targets or as an on-chip self-test progress
// indicator.
//
// Event classes (per valid channel; one retirement may hit several):
//   0 dmemrd : rvfi_mem_rmask != 0
//   1 dmemwr : rvfi_mem_wmask != 0
//   2 long   : insn[1:0] == 2'b11
//   3 compr  : insn[1:0] != 2'b11 when COMPR_EN=1, otherwise every retirement
//   4 trap   : rvfi_trap
//
// Parameters:
//   NRET        retire channels per cycle (1..4)
//   CNT_W       counter width per class (2..16)
//   GOAL        per-class target count (1..2**CNT_W-1)
//   COMPR_EN    selects the meaning of class 3 (see above)
//   START_ARMED 1: the reset state is RUN, 0: the reset state is IDLE
//
// Ports:
//   clk, resetn     clock; synchronous active-low reset
//   rvfi_valid      [NRET]      per-channel retirement valid
//   rvfi_insn       [32*NRET]   channel k at [32k+31:32k]
//   rvfi_trap       [NRET]      per-channel trap
//   rvfi_mem_rmask  [4*NRET]    per-channel read byte mask
//   rvfi_mem_wmask  [4*NRET]    per-channel write byte mask
//   arm             IDLE->RUN request
//   clear           zero the counters and return to the reset state
//   cnt             [5*CNT_W]   class c counter at [CNT_W*c +: CNT_W]
//   hit             [5]         cnt[c] >= 1
//   goal            [5]         cnt[c] >= GOAL
//   done            state == DONE
//   state           [2]         0 IDLE, 1 RUN, 2 DONE (FSM debug view)
//
// There is no handshake on this block. rvfi_* fields of a channel are only
// looked at while that channel's rvfi_valid bit is 1; arm and clear are
// single-cycle level requests sampled on every rising edge of clk.
// -----------------------------------------------------------------------------
module rvfi_cover_monitor #(
  parameter int NRET        = 1,
  parameter int CNT_W       = 8,
  parameter int GOAL        = 2,
  parameter int COMPR_EN    = 0,
  parameter int START_ARMED = 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NRET-1:0]      rvfi_valid,
  input  logic [32*NRET-1:0]   rvfi_insn,
  input  logic [NRET-1:0]      rvfi_trap,
  input  logic [4*NRET-1:0]    rvfi_mem_rmask,
  input  logic [4*NRET-1:0]    rvfi_mem_wmask,
  input  logic                 arm,
  input  logic                 clear,
  output logic [5*CNT_W-1:0]   cnt,
  output logic [4:0]           hit,
  output logic [4:0]           goal,
  output logic                 done,
  output logic [1:0]           state
);

  localparam int NCLS = 5;
  localparam int SUM_W = CNT_W + 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam state_t RESET_STATE = (START_ARMED != 0) ? ST_RUN : ST_IDLE;

  // Saturation ceiling expressed in the widened sum domain.
  localparam logic [SUM_W-1:0]  SAT_MAX = {3'b000, {CNT_W{1'b1}}};
  localparam logic [CNT_W-1:0]  GOAL_V  = CNT_W'(GOAL);

  state_t state_q, state_d;

  logic [CNT_W-1:0] cnt_q   [NCLS];
  logic [CNT_W-1:0] cnt_d   [NCLS];
  logic [CNT_W-1:0] cnt_sat [NCLS];
  logic [SUM_W-1:0] sum     [NCLS];
  logic [2:0]       inc     [NCLS];

  // Class membership per channel, already qualified by rvfi_valid so that
  // fields of an idle channel can never leak into a count.
  logic [NCLS-1:0]  cls     [NRET];
  logic [NRET-1:0]  unused_insn;

  for (genvar k = 0; k < NRET; k++) begin : g_chan
    logic [1:0] insn_lo;
    logic       compr_hit;

    assign insn_lo   = rvfi_insn[32*k +: 2];
    assign compr_hit = (COMPR_EN != 0) ? (insn_lo != 2'b11) : 1'b1;

    assign cls[k][0] = rvfi_valid[k] & (|rvfi_mem_rmask[4*k +: 4]);
    assign cls[k][1] = rvfi_valid[k] & (|rvfi_mem_wmask[4*k +: 4]);
    assign cls[k][2] = rvfi_valid[k] & (insn_lo == 2'b11);
    assign cls[k][3] = rvfi_valid[k] & compr_hit;
    assign cls[k][4] = rvfi_valid[k] & rvfi_trap[k];

    // Only the length bits of the instruction word matter here.
    assign unused_insn[k] = ^rvfi_insn[32*k+2 +: 30];
  end

  // Per-class population count across channels (0..NRET, fits in 3 bits).
  always_comb begin
    for (int c = 0; c < NCLS; c++) begin
      inc[c] = 3'd0;
      for (int k = 0; k < NRET; k++) begin
        inc[c] = inc[c] + {2'b00, cls[k][c]};
      end
    end
  end

  // Widened add so the carry out of the counter is observable, then clamp.
  always_comb begin
    for (int c = 0; c < NCLS; c++) begin
      sum[c]     = {3'b000, cnt_q[c]} + {{CNT_W{1'b0}}, inc[c]};
      cnt_sat[c] = (sum[c] > SAT_MAX) ? {CNT_W{1'b1}} : sum[c][CNT_W-1:0];
    end
  end

  // Next-state / next-count logic. The DONE decision looks at the counts
  // that are about to be written, so the final counts and done become
  // visible on the same edge.
  logic all_goal_next;

  always_comb begin
    state_d       = state_q;
    all_goal_next = 1'b1;
    for (int c = 0; c < NCLS; c++) begin
      cnt_d[c] = cnt_q[c];
      if (cnt_sat[c] < GOAL_V) begin
        all_goal_next = 1'b0;
      end
    end

    if (clear) begin
      // clear beats any retirement or arm in the same cycle.
      for (int c = 0; c < NCLS; c++) begin
        cnt_d[c] = '0;
      end
      state_d = RESET_STATE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (arm) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          for (int c = 0; c < NCLS; c++) begin
            cnt_d[c] = cnt_sat[c];
          end
          if (all_goal_next) begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = RESET_STATE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= RESET_STATE;
      for (int c = 0; c < NCLS; c++) begin
        cnt_q[c] <= '0;
      end
    end else begin
      state_q <= state_d;
      for (int c = 0; c < NCLS; c++) begin
        cnt_q[c] <= cnt_d[c];
      end
    end
  end

  for (genvar c = 0; c < NCLS; c++) begin : g_out
    assign cnt[CNT_W*c +: CNT_W] = cnt_q[c];
    assign hit[c]                = (cnt_q[c] != '0);
    assign goal[c]               = (cnt_q[c] >= GOAL_V);
  end

  assign done  = (state_q == ST_DONE);
  assign state = state_q;

endmodule

// File: tb/tb_rvfi_cover_monitor.sv
// -----------------------------------------------------------------------------
// tb_rvfi_cover_monitor
//
// Two monitor instances with different parameter sets run side by side:
//   a: NRET=2, CNT_W=8, GOAL=2, COMPR_EN=0, START_ARMED=1
//   b: NRET=1, CNT_W=2, GOAL=3, COMPR_EN=1, START_ARMED=0
// A behavioural model (plain integer counts and a state number) is stepped
// alongside both instances and every output is compared after every edge.
// Directed steps come first, then a randomized phase.
// -----------------------------------------------------------------------------
module tb_rvfi_cover_monitor;

  localparam int A_NRET = 2, A_W = 8, A_GOAL = 2, A_COMPR = 0, A_ARMED = 1;
  localparam int B_NRET = 1, B_W = 2, B_GOAL = 3, B_COMPR = 1, B_ARMED = 0;

  localparam logic [31:0] LW    = 32'h0002_a303;
  localparam logic [31:0] SW    = 32'h0062_a023;
  localparam logic [31:0] ECALL = 32'h0000_0073;
  localparam logic [31:0] C_LI  = 32'h0000_4505;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // instance a signals
  logic                 resetn_a, arm_a, clear_a;
  logic [A_NRET-1:0]    valid_a, trap_a;
  logic [32*A_NRET-1:0] insn_a;
  logic [4*A_NRET-1:0]  rm_a, wm_a;
  logic [5*A_W-1:0]     cnt_a;
  logic [4:0]           hit_a, goal_a;
  logic                 done_a;
  logic [1:0]           state_a;

  // instance b signals
  logic                 resetn_b, arm_b, clear_b;
  logic [B_NRET-1:0]    valid_b, trap_b;
  logic [32*B_NRET-1:0] insn_b;
  logic [4*B_NRET-1:0]  rm_b, wm_b;
  logic [5*B_W-1:0]     cnt_b;
  logic [4:0]           hit_b, goal_b;
  logic                 done_b;
  logic [1:0]           state_b;

  rvfi_cover_monitor #(
    .NRET(A_NRET), .CNT_W(A_W), .GOAL(A_GOAL), .COMPR_EN(A_COMPR), .START_ARMED(A_ARMED)
  ) u_a (
    .clk(clk), .resetn(resetn_a), .rvfi_valid(valid_a), .rvfi_insn(insn_a),
    .rvfi_trap(trap_a), .rvfi_mem_rmask(rm_a), .rvfi_mem_wmask(wm_a),
    .arm(arm_a), .clear(clear_a), .cnt(cnt_a), .hit(hit_a), .goal(goal_a),
    .done(done_a), .state(state_a)
  );

  rvfi_cover_monitor #(
    .NRET(B_NRET), .CNT_W(B_W), .GOAL(B_GOAL), .COMPR_EN(B_COMPR), .START_ARMED(B_ARMED)
  ) u_b (
    .clk(clk), .resetn(resetn_b), .rvfi_valid(valid_b), .rvfi_insn(insn_b),
    .rvfi_trap(trap_b), .rvfi_mem_rmask(rm_b), .rvfi_mem_wmask(wm_b),
    .arm(arm_b), .clear(clear_b), .cnt(cnt_b), .hit(hit_b), .goal(goal_b),
    .done(done_b), .state(state_b)
  );

  // scoreboard state
  int n_checks = 0;
  int n_fail   = 0;
  int m_cnt [2][5];
  int m_st  [2];   // 0 idle, 1 run, 2 done

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Does one valid retirement belong to class c?
  function automatic bit member(input int c, input logic [31:0] i, input logic tr,
                                input logic [3:0] r, input logic [3:0] w, input int cm);
    case (c)
      0:       return r != 4'h0;
      1:       return w != 4'h0;
      2:       return i[1:0] == 2'b11;
      3:       return (cm != 0) ? (i[1:0] != 2'b11) : 1'b1;
      default: return tr;
    endcase
  endfunction

  // Advance the model of instance id by one edge using the current inputs.
  task automatic model_step(input int id);
    logic [3:0]   v, t;
    logic [127:0] ins;
    logic [15:0]  r, w;
    logic         rn, clr, ar;
    int           nret, wdt, gl, cm, armd, mx, inc;
    bit           all_met;
    v = '0; t = '0; ins = '0; r = '0; w = '0;
    if (id == 0) begin
      v[A_NRET-1:0] = valid_a; t[A_NRET-1:0] = trap_a; ins[32*A_NRET-1:0] = insn_a;
      r[4*A_NRET-1:0] = rm_a; w[4*A_NRET-1:0] = wm_a;
      rn = resetn_a; clr = clear_a; ar = arm_a;
      nret = A_NRET; wdt = A_W; gl = A_GOAL; cm = A_COMPR; armd = A_ARMED;
    end else begin
      v[B_NRET-1:0] = valid_b; t[B_NRET-1:0] = trap_b; ins[32*B_NRET-1:0] = insn_b;
      r[4*B_NRET-1:0] = rm_b; w[4*B_NRET-1:0] = wm_b;
      rn = resetn_b; clr = clear_b; ar = arm_b;
      nret = B_NRET; wdt = B_W; gl = B_GOAL; cm = B_COMPR; armd = B_ARMED;
    end
    mx = (1 << wdt) - 1;
    if (!rn || clr) begin
      for (int c = 0; c < 5; c++) m_cnt[id][c] = 0;
      m_st[id] = (armd != 0) ? 1 : 0;
    end else if (m_st[id] == 0) begin
      if (ar) m_st[id] = 1;
    end else if (m_st[id] == 1) begin
      all_met = 1'b1;
      for (int c = 0; c < 5; c++) begin
        inc = 0;
        for (int k = 0; k < nret; k++)
          if (v[k] && member(c, ins[32*k +: 32], t[k], r[4*k +: 4], w[4*k +: 4], cm)) inc++;
        m_cnt[id][c] = (m_cnt[id][c] + inc > mx) ? mx : m_cnt[id][c] + inc;
        if (m_cnt[id][c] < gl) all_met = 1'b0;
      end
      if (all_met) m_st[id] = 2;
    end
  endtask

  task automatic check_inst(input int id);
    logic [4:0] eh, eg;
    logic [31:0] obs;
    string nm;
    int gl;
    nm = (id == 0) ? "a" : "b";
    gl = (id == 0) ? A_GOAL : B_GOAL;
    for (int c = 0; c < 5; c++) begin
      obs = (id == 0) ? 32'(cnt_a[A_W*c +: A_W]) : 32'(cnt_b[B_W*c +: B_W]);
      chk($sformatf("%s_cnt%0d", nm, c), obs, 32'(m_cnt[id][c]));
      eh[c] = m_cnt[id][c] >= 1;
      eg[c] = m_cnt[id][c] >= gl;
    end
    chk({nm, "_hit"},   32'((id == 0) ? hit_a : hit_b),     32'(eh));
    chk({nm, "_goal"},  32'((id == 0) ? goal_a : goal_b),   32'(eg));
    chk({nm, "_done"},  32'((id == 0) ? done_a : done_b),   32'(m_st[id] == 2));
    chk({nm, "_state"}, 32'((id == 0) ? state_a : state_b), 32'(m_st[id]));
  endtask

  // One clock: step the models on the current inputs, then compare after the edge.
  task automatic tick();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    check_inst(0);
    check_inst(1);
  endtask

  // driver tasks
  task automatic quiet_a();
    valid_a = '0;
    for (int k = 0; k < A_NRET; k++) begin
      insn_a[32*k +: 32] = $urandom;
      rm_a[4*k +: 4] = 4'($urandom_range(0, 15));
      wm_a[4*k +: 4] = 4'($urandom_range(0, 15));
      trap_a[k] = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic quiet_b();
    valid_b   = '0;
    insn_b    = $urandom;
    rm_b      = 4'($urandom_range(0, 15));
    wm_b      = 4'($urandom_range(0, 15));
    trap_b[0] = 1'($urandom_range(0, 1));
  endtask

  task automatic ret_a(input int k, input logic [31:0] ins, input logic [3:0] r,
                       input logic [3:0] w, input logic t);
    valid_a[k] = 1'b1; insn_a[32*k +: 32] = ins;
    rm_a[4*k +: 4] = r; wm_a[4*k +: 4] = w; trap_a[k] = t;
  endtask

  task automatic ret_b(input logic [31:0] ins, input logic [3:0] r,
                       input logic [3:0] w, input logic t);
    valid_b[0] = 1'b1; insn_b = ins; rm_b = r; wm_b = w; trap_b[0] = t;
  endtask

  function automatic logic [3:0] rand_mask();
    return ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
  endfunction

  logic [31:0] seq_insn [6];
  logic [3:0]  seq_r    [6];
  logic [3:0]  seq_w    [6];
  logic        seq_t    [6];

  initial begin
    seq_insn = '{LW, SW, ECALL, LW, SW, ECALL};
    seq_r    = '{4'hF, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0};
    seq_w    = '{4'h0, 4'h3, 4'h0, 4'h0, 4'h3, 4'h0};
    seq_t    = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    resetn_a = 1'b0; arm_a = 1'b0; clear_a = 1'b0;
    resetn_b = 1'b0; arm_b = 1'b0; clear_b = 1'b0;
    quiet_a(); quiet_b();
    for (int c = 0; c < 5; c++) begin m_cnt[0][c] = 0; m_cnt[1][c] = 0; end
    m_st[0] = 0; m_st[1] = 0;
    tick(); tick();
    chk("reset_a_state", 32'(state_a), 32'd1);
    chk("reset_a_cnt",   32'(cnt_a == '0), 32'd1);
    chk("reset_b_state", 32'(state_b), 32'd0);
    resetn_a = 1'b1; resetn_b = 1'b1;
    tick();

    // a: one LW on channel 0
    quiet_a(); ret_a(0, LW, 4'hF, 4'h0, 1'b0);
    tick();
    chk("lw_hit", 32'(hit_a), 32'(5'b01101));
    chk("lw_cnt0", 32'(cnt_a[7:0]), 32'd1);

    // a: two stores in the same cycle
    quiet_a(); ret_a(0, SW, 4'h0, 4'h3, 1'b0); ret_a(1, SW, 4'h0, 4'h3, 1'b0);
    tick();
    chk("dual_sw_cnt1", 32'(cnt_a[15:8]), 32'd2);
    chk("dual_sw_goal1", 32'(goal_a[1]), 32'd1);

    // a: clear, then run the sequence that reaches DONE on the last trap
    quiet_a(); clear_a = 1'b1;
    tick();
    clear_a = 1'b0;
    chk("clear_cnt", 32'(cnt_a == '0), 32'd1);
    for (int s = 0; s < 6; s++) begin
      quiet_a(); ret_a(0, seq_insn[s], seq_r[s], seq_w[s], seq_t[s]);
      tick();
      chk($sformatf("seq_done%0d", s), 32'(done_a), 32'(s == 5));
    end
    quiet_a(); ret_a(0, LW, 4'hF, 4'h0, 1'b0); ret_a(1, SW, 4'h0, 4'h1, 1'b1);
    tick();
    chk("frozen_cnt0", 32'(cnt_a[7:0]), 32'd2);

    // a: clear in DONE with a concurrent LW and arm
    quiet_a(); ret_a(0, LW, 4'hF, 4'h0, 1'b0); clear_a = 1'b1; arm_a = 1'b1;
    tick();
    clear_a = 1'b0; arm_a = 1'b0;
    chk("clr_done_cnt", 32'(cnt_a == '0), 32'd1);
    chk("clr_done_state", 32'(state_a), 32'd1);

    // a: mid-run reset
    quiet_a(); ret_a(0, LW, 4'hF, 4'h0, 1'b0); tick();
    quiet_a(); ret_a(1, SW, 4'h0, 4'hC, 1'b0); tick();
    quiet_a(); ret_a(0, LW, 4'hF, 4'h0, 1'b1); resetn_a = 1'b0;
    tick();
    resetn_a = 1'b1;
    chk("midrst_cnt", 32'(cnt_a == '0), 32'd1);
    chk("midrst_hit", 32'(hit_a), 32'd0);
    chk("midrst_state", 32'(state_a), 32'd1);
    quiet_a();

    // b: retirements in IDLE are ignored
    for (int s = 0; s < 3; s++) begin
      quiet_b(); ret_b(LW, 4'hF, 4'h0, 1'b0);
      tick();
    end
    chk("idle_cnt", 32'(cnt_b == '0), 32'd1);
    quiet_b(); arm_b = 1'b1;
    tick();
    arm_b = 1'b0;
    chk("arm_state", 32'(state_b), 32'd1);
    quiet_b(); ret_b(C_LI, 4'h0, 4'h0, 1'b0);
    tick();
    chk("after_arm_cnt3", 32'(cnt_b[7:6]), 32'd1);

    // b: saturating read counter, 1,2,3,3,3
    for (int s = 0; s < 5; s++) begin
      quiet_b(); ret_b(LW, 4'hF, 4'h0, 1'b0);
      tick();
      chk($sformatf("sat_cnt0_%0d", s), 32'(cnt_b[1:0]), 32'((s < 3) ? s + 1 : 3));
    end

    // randomized phase on both instances
    for (int n = 0; n < 400; n++) begin
      resetn_a = ($urandom_range(0, 99) != 0);
      clear_a  = ($urandom_range(0, 29) == 0);
      arm_a    = ($urandom_range(0, 7) == 0);
      for (int k = 0; k < A_NRET; k++) begin
        valid_a[k] = 1'($urandom_range(0, 1));
        insn_a[32*k +: 32] = $urandom;
        rm_a[4*k +: 4] = rand_mask();
        wm_a[4*k +: 4] = rand_mask();
        trap_a[k] = ($urandom_range(0, 5) == 0);
      end
      resetn_b = ($urandom_range(0, 99) != 0);
      clear_b  = ($urandom_range(0, 49) == 0);
      arm_b    = ($urandom_range(0, 7) == 0);
      valid_b[0] = 1'($urandom_range(0, 1));
      insn_b = $urandom;
      rm_b = rand_mask();
      wm_b = rand_mask();
      trap_b[0] = ($urandom_range(0, 4) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
